// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for the iterative MUL/DIV unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign correction of magnitude results: 2W product negation for MUL,
// independent quotient/remainder negation for DIV. Zero latency, no flow control.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic             neg_lo,
  input  logic             neg_hi,
  input  logic [WIDTH-1:0] mag_hi,
  input  logic [WIDTH-1:0] mag_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_neg;

  assign prod_mag = {mag_hi, mag_lo};
  assign prod_neg = -prod_mag;

  always_comb begin
    res_hi = mag_hi;
    res_lo = mag_lo;
    if (!is_div) begin
      if (neg_lo) begin
        {res_hi, res_lo} = prod_neg;
      end
    end else begin
      // Quotient sign and remainder sign are corrected independently.
      if (neg_lo) res_lo = -mag_lo;
      if (neg_hi) res_hi = -mag_hi;
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative 1-bit/cycle signed/unsigned MUL and restoring DIV; done WIDTH+2 cycles after start
// (1 cycle for div-by-zero / overflow). start is ignored while busy; flush aborts to IDLE.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               rsgn_q, rsgn_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;

  logic               opa_neg, opb_neg;
  logic [WIDTH-1:0]   opa_mag, opb_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign opa_neg = op_is_signed(op) & opa[WIDTH-1];
  assign opb_neg = op_is_signed(op) & opb[WIDTH-1];
  assign opa_mag = opa_neg ? -opa : opa;
  assign opb_mag = opb_neg ? -opb : opb;

  // MUL: acc = {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // DIV: acc = {partial remainder, dividend/quotient}; shift left, trial subtract.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
  assign div_next  = div_trial[WIDTH]
                   ? {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .is_div (op_is_div(op_q)),
    .neg_lo (sgn_q),
    .neg_hi (rsgn_q),
    .mag_hi (acc_q[2*WIDTH-1:WIDTH]),
    .mag_lo (acc_q[WIDTH-1:0]),
    .res_hi (fix_hi),
    .res_lo (fix_lo)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    rsgn_d  = rsgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_d    = op;
            a_d     = opa_mag;
            b_d     = opb_mag;
            sgn_d   = opa_neg ^ opb_neg;
            rsgn_d  = opa_neg;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            cnt_d   = CNT_W'(WIDTH - 1);
            acc_d   = op_is_div(op) ? {{WIDTH{1'b0}}, opa_mag} : {{WIDTH{1'b0}}, opb_mag};
            state_d = RUN;
            if (op_is_div(op) && (opb == '0)) begin
              dz_d    = 1'b1;
              lo_d    = '1;
              hi_d    = opa;
              state_d = DONE;
            end else if ((op == OP_DIV) && (opa == MIN_NEG) && (opb == '1)) begin
              ovf_d   = 1'b1;
              lo_d    = opa;
              hi_d    = '0;
              state_d = DONE;
            end
          end
        end
        RUN: begin
          acc_d = op_is_div(op_q) ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = FIX;
        end
        FIX: begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      rsgn_q  <= rsgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign ovf      = ovf_q;

endmodule
